// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master (CPU/DMA) data-memory bus arbiter with DMA starvation guard
//
// Purpose: shares one data-memory/peripheral bus between the CPU MEM stage and
// the UART loader/debug DMA. The CPU normally wins. After MAX_WAIT consecutive
// denied DMA cycles, the next cycle is a forced DMA slot, and the CPU is stalled
// for that one cycle.
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata MEM-stage access request
//   cpu_rdata, cpu_stall             read data (mem_rdata) and pipeline hold
//   dma_req/dma_we/dma_addr/dma_wdata DMA access request, held until granted
//   dma_gnt                          combinational grant for this cycle
//   dma_rdata, dma_rvalid            registered read return, one cycle after grant
//   mem_rd/mem_wr/mem_addr/mem_wdata shared-bus strobes, address and write data
//   mem_rdata                        shared-bus read data, same cycle
module dmem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_FORCE  = 1'b1
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              cpu_act;
    logic              dma_denied;

    assign cpu_act = cpu_rd | cpu_wr;

    // Arbitration, wait counter and next state. None of this depends on
    // mem_rdata, so there is no combinational path from read data to control.
    always_comb begin
        dma_gnt    = 1'b0;
        cpu_stall  = 1'b0;
        state_d    = S_NORMAL;
        wait_cnt_d = '0;
        dma_denied = 1'b0;

        case (state_q)
            S_NORMAL: begin
                dma_gnt = dma_req & ~cpu_act;
            end
            S_FORCE: begin
                // Forced slot lasts exactly one cycle, whether or not it is used.
                dma_gnt   = dma_req;
                cpu_stall = cpu_act & dma_req;
            end
            default: begin
                dma_gnt = 1'b0;
            end
        endcase

        dma_denied = dma_req & ~dma_gnt;

        if (dma_denied) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        // The denial that brings the count to MAX_WAIT schedules the forced slot.
        if (state_q == S_NORMAL && dma_denied && wait_cnt_q == WAIT_LAST) begin
            state_d = S_FORCE;
        end
    end

    // Bus mux: the granted DMA owns the bus; otherwise the CPU request passes
    // through, masked only by a stall. An idle bus still shows the CPU address.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd & ~cpu_stall;
        mem_wr    = cpu_wr & ~cpu_stall;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_rd    = ~dma_we;
            mem_wr    = dma_we;
        end
    end

    assign cpu_rdata = mem_rdata;

    always_comb begin
        rvalid_d = dma_gnt & ~dma_we;
        rdata_d  = rdata_q;
        if (dma_gnt && !dma_we) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_NORMAL;
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard testbench for dmem_arbiter (MAX_WAIT = 4)
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string       nm;
        logic        gnt, stall, mrd, mwr;
        logic [31:0] maddr;
        logic        rv;
        logic        chk_drd;
        logic [31:0] drd;
        logic        chk_crd;
        logic [31:0] crd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Bus-side memory: combinational read, write at the rising edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    end

    function automatic void chk(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s.%s: got %08h want %08h", nm, fld, act, exp_v);
        end
    endfunction

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "dma_gnt",    32'(dma_gnt),    32'(e.gnt));
            chk(e.nm, "cpu_stall",  32'(cpu_stall),  32'(e.stall));
            chk(e.nm, "mem_rd",     32'(mem_rd),     32'(e.mrd));
            chk(e.nm, "mem_wr",     32'(mem_wr),     32'(e.mwr));
            chk(e.nm, "mem_addr",   mem_addr,        e.maddr);
            chk(e.nm, "dma_rvalid", 32'(dma_rvalid), 32'(e.rv));
            if (e.chk_drd) chk(e.nm, "dma_rdata", dma_rdata, e.drd);
            if (e.chk_crd) chk(e.nm, "cpu_rdata", cpu_rdata, e.crd);
        end
    end

    task automatic cyc(input string nm, input logic rst,
                       input logic crd, input logic cwr, input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                       input logic egnt, input logic est, input logic emrd, input logic emwr,
                       input logic [31:0] emaddr, input logic erv,
                       input logic cdrd, input logic [31:0] edrd,
                       input logic ccrd, input logic [31:0] ecrd);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        e.nm = nm; e.gnt = egnt; e.stall = est; e.mrd = emrd; e.mwr = emwr;
        e.maddr = emaddr; e.rv = erv; e.chk_drd = cdrd; e.drd = edrd;
        e.chk_crd = ccrd; e.crd = ecrd;
        sb.push_back(e);
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] V20 = 32'h12345678;
    localparam logic [31:0] V24 = 32'hA5A50024;
    localparam logic [31:0] CF = 32'hCAFEF00D;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[9] = V24;

        // name      rst crd cwr caddr  cwd  dreq dwe daddr  dwd   gnt st mrd mwr maddr rv cdrd drd cc crd
        cyc("reset",  0, 0,0, 32'h0, 0,    0,0, 32'h0, 0,    0,0,0,0, 32'h0, 0, 1,0, 0,0);
        cyc("release",1, 0,0, 32'h0, 0,    0,0, 32'h0, 0,    0,0,0,0, 32'h0, 0, 1,0, 0,0);
        cyc("dma_wr", 1, 0,0, 32'h0, 0,    1,1, 32'h10,DB,   1,0,0,1, 32'h10,0, 1,0, 0,0);
        cyc("cpu_rd10",1,1,0, 32'h10,0,    0,0, 32'h0, 0,    0,0,1,0, 32'h10,0, 0,0, 1,DB);
        cyc("cpu_wr20",1,0,1, 32'h20,V20,  0,0, 32'h0, 0,    0,0,0,1, 32'h20,0, 0,0, 0,0);
        cyc("dma_rd", 1, 0,0, 32'h0, 0,    1,0, 32'h20,0,    1,0,1,0, 32'h20,0, 1,0, 0,0);
        cyc("rvalid", 1, 0,0, 32'h0, 0,    0,0, 32'h0, 0,    0,0,0,0, 32'h0, 1, 1,V20, 0,0);
        cyc("rv_drop",1, 0,0, 32'h0, 0,    0,0, 32'h0, 0,    0,0,0,0, 32'h0, 0, 1,V20, 0,0);
        cyc("b2b_0",  1, 0,0, 32'h0, 0,    1,0, 32'h10,0,    1,0,1,0, 32'h10,0, 0,0, 0,0);
        cyc("b2b_1",  1, 0,0, 32'h0, 0,    1,0, 32'h20,0,    1,0,1,0, 32'h20,1, 1,DB, 0,0);
        cyc("b2b_2",  1, 0,0, 32'h0, 0,    0,0, 32'h0, 0,    0,0,0,0, 32'h0, 1, 1,V20, 0,0);
        cyc("b2b_3",  1, 0,0, 32'h0, 0,    0,0, 32'h0, 0,    0,0,0,0, 32'h0, 0, 1,V20, 0,0);

        // Starvation: CPU reads 0x20 continuously.
        for (int i = 0; i < 4; i++)
            cyc("deny_a", 1, 1,0, 32'h20,0, 1,0, 32'h10,0, 0,0,1,0, 32'h20,0, 1,V20, 1,V20);
        cyc("force_a",1, 1,0, 32'h20,0,    1,0, 32'h10,0,    1,1,1,0, 32'h10,0, 0,0, 0,0);
        cyc("served_a",1,1,0, 32'h20,0,    1,0, 32'h24,0,    0,0,1,0, 32'h20,1, 1,DB, 1,V20);
        for (int i = 0; i < 3; i++)
            cyc("deny_b", 1, 1,0, 32'h20,0, 1,0, 32'h24,0, 0,0,1,0, 32'h20,0, 1,DB, 0,0);
        cyc("force_b",1, 1,0, 32'h20,0,    1,0, 32'h24,0,    1,1,1,0, 32'h24,0, 0,0, 0,0);
        cyc("served_b",1,1,0, 32'h20,0,    1,1, 32'h30,CF,   0,0,1,0, 32'h20,1, 1,V24, 1,V20);
        for (int i = 0; i < 3; i++)
            cyc("deny_c", 1, 1,0, 32'h20,0, 1,1, 32'h30,CF, 0,0,1,0, 32'h20,0, 0,0, 0,0);
        cyc("force_drop",1,1,0,32'h20,0,   0,0, 32'h0, 0,    0,0,1,0, 32'h20,0, 0,0, 1,V20);
        for (int i = 0; i < 4; i++)
            cyc("deny_d", 1, 1,0, 32'h20,0, 1,1, 32'h30,CF, 0,0,1,0, 32'h20,0, 0,0, 0,0);
        cyc("force_wr",1,1,0, 32'h20,0,    1,1, 32'h30,CF,   1,1,0,1, 32'h30,0, 0,0, 0,0);
        cyc("cpu_rd30",1,1,0, 32'h30,0,    0,0, 32'h0, 0,    0,0,1,0, 32'h30,0, 0,0, 1,CF);
        cyc("rd_and_wr",1,1,1,32'h40,32'h1,0,0, 32'h0, 0,    0,0,1,1, 32'h40,0, 0,0, 0,0);

        for (int i = 0; i < 20; i++)
            cyc("idle", 1, 0,0, 32'(i*4),0, 0,0, 32'h0,0, 0,0,0,0, 32'(i*4),0, 0,0, 0,0);

        // Reset while in the forced slot.
        for (int i = 0; i < 4; i++)
            cyc("deny_f", 1, 1,0, 32'h20,0, 1,0, 32'h10,0, 0,0,1,0, 32'h20,0, 0,0, 0,0);
        cyc("rst_force",0,1,0,32'h20,0,    1,0, 32'h10,0,    0,0,1,0, 32'h20,0, 1,0, 0,0);
        cyc("after_rf",1, 0,0, 32'h0, 0,   0,0, 32'h0, 0,    0,0,0,0, 32'h0, 0, 1,0, 0,0);

        // Reset while a read return is pending.
        cyc("rd_pend",1, 0,0, 32'h0, 0,    1,0, 32'h20,0,    1,0,1,0, 32'h20,0, 1,0, 0,0);
        cyc("rst_rv", 0, 1,0, 32'h10,0,    0,0, 32'h0, 0,    0,0,1,0, 32'h10,0, 1,0, 1,DB);
        cyc("after_rv",1, 0,0, 32'h0, 0,   0,0, 32'h0, 0,    0,0,0,0, 32'h0, 0, 1,0, 0,0);

        // Reset mid-wait (count at 3): forcing again needs four full denials.
        for (int i = 0; i < 3; i++)
            cyc("deny_g", 1, 1,0, 32'h20,0, 1,0, 32'h10,0, 0,0,1,0, 32'h20,0, 0,0, 0,0);
        cyc("rst_wait",0, 1,0, 32'h20,0,   1,0, 32'h10,0,    0,0,1,0, 32'h20,0, 1,0, 0,0);
        for (int i = 0; i < 4; i++)
            cyc("deny_h", 1, 1,0, 32'h20,0, 1,0, 32'h10,0, 0,0,1,0, 32'h20,0, 0,0, 0,0);
        cyc("force_h",1, 1,0, 32'h20,0,    1,0, 32'h10,0,    1,1,1,0, 32'h10,0, 0,0, 0,0);
        cyc("served_h",1,1,0, 32'h20,0,    0,0, 32'h0, 0,    0,0,1,0, 32'h20,1, 1,DB, 1,V20);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
